// File: rtl/reg_cmd_sequencer.sv
// Command sequencer for an E/FunSel register: expands one accepted command into
// the per-cycle E/FunSel/I stream and tracks the resulting register value in Shadow.
module reg_cmd_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [1:0]       cmd_op_i,
   input  logic [WIDTH-1:0] cmd_data_i,
   input  logic [CNT_W-1:0] cmd_count_i,
   output logic             e_o,
   output logic [1:0]       funsel_o,
   output logic [WIDTH-1:0] i_o,
   output logic [WIDTH-1:0] shadow_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam logic [1:0] OP_DOWN  = 2'b00;
   localparam logic [1:0] OP_UP    = 2'b01;
   localparam logic [1:0] OP_LOAD  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             e_q;
   logic [1:0]       funsel_q;
   logic [WIDTH-1:0] i_q;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             done_q;

   // Shadow follows exactly what the target register does on an enabled edge.
   always_comb begin
      shadow_d = shadow_q;
      if (e_q) begin
         case (funsel_q)
            OP_DOWN:  shadow_d = shadow_q - WIDTH'(1);
            OP_UP:    shadow_d = shadow_q + WIDTH'(1);
            OP_LOAD:  shadow_d = i_q;
            OP_CLEAR: shadow_d = '0;
            default:  shadow_d = shadow_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         e_q      <= 1'b0;
         funsel_q <= OP_DOWN;
         i_q      <= '0;
         shadow_q <= '0;
         done_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (cmd_valid_i) begin
                  if (!cmd_op_i[1] && cmd_count_i == '0) begin
                     // Zero-length step: complete without touching the register.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q  <= S_ISSUE;
                     e_q      <= 1'b1;
                     funsel_q <= cmd_op_i;
                     i_q      <= (cmd_op_i == OP_LOAD) ? cmd_data_i : '0;
                     cnt_q    <= cmd_op_i[1] ? CNT_W'(1) : cmd_count_i;
                  end
               end
            end
            S_ISSUE: begin
               if (cnt_q == CNT_W'(1)) begin
                  e_q     <= 1'b0;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               e_q     <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign e_o         = e_q;
   assign funsel_o    = funsel_q;
   assign i_o         = i_q;
   assign shadow_o    = shadow_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Bench for reg_cmd_sequencer: command scoreboard plus a behavioural target-register model.
module tb_reg_cmd_sequencer;
   localparam int W = 16;
   localparam int C = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid = 1'b0;
   logic [1:0]   op = 2'b00;
   logic [W-1:0] data = '0;
   logic [C-1:0] count = '0;
   logic         ready, e, busy, done;
   logic [1:0]   funsel;
   logic [W-1:0] i_bus, shadow;

   reg_cmd_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
      .clk_i(clk), .rst_i(rst), .cmd_valid_i(valid), .cmd_ready_o(ready),
      .cmd_op_i(op), .cmd_data_i(data), .cmd_count_i(count),
      .e_o(e), .funsel_o(funsel), .i_o(i_bus), .shadow_o(shadow),
      .busy_o(busy), .done_o(done));

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   op;
      int           n;
      logic [W-1:0] sh;
      int           acc;
   } exp_t;

   exp_t         q[$];
   int           checks = 0, errors = 0, cyc = 0, acc_total = 0;
   int           cur_ecnt = 0, cur_efirst = 0, cur_elast = 0;
   logic [W-1:0] exp_sh = '0, mdl = '0;
   bit           synced = 1'b0;

   // Reset abandons any outstanding command and the register model loses sync.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q.delete();
         exp_sh = '0;
         synced = 1'b0;
      end
   end

   always @(negedge clk) begin
      bit   sync_set;
      exp_t x;
      sync_set = 1'b0;
      if (synced) begin
         checks++;
         if (mdl !== shadow) begin
            errors++;
            $display("FAIL model_vs_shadow cyc=%0d shadow=%h model=%h", cyc, shadow, mdl);
         end
      end
      if (e === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL e_without_cmd cyc=%0d e=%b expected 0", cyc, e);
         end else begin
            if (funsel !== q[0].op) begin
               errors++;
               $display("FAIL funsel cyc=%0d got=%b exp=%b", cyc, funsel, q[0].op);
            end
            if (cur_ecnt == 0) cur_efirst = cyc;
            cur_elast = cyc;
            cur_ecnt++;
         end
         if (funsel != 2'b10) begin
            checks++;
            if (i_bus !== '0) begin
               errors++;
               $display("FAIL i_nonload cyc=%0d got=%h exp=0", cyc, i_bus);
            end
         end
         case (funsel)
            2'b00: mdl = mdl - 1'b1;
            2'b01: mdl = mdl + 1'b1;
            2'b10: begin mdl = i_bus; sync_set = 1'b1; end
            default: begin mdl = '0; sync_set = 1'b1; end
         endcase
      end
      if (q.size() != 0) begin
         checks++;
         if (ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_busy cyc=%0d got=%b exp=0", cyc, ready);
         end
      end
      if (done === 1'b1) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done cyc=%0d done=1 expected 0", cyc);
         end else begin
            x = q.pop_front();
            if (cur_ecnt != x.n) begin
               errors++;
               $display("FAIL e_count got=%0d exp=%0d", cur_ecnt, x.n);
            end
            if (x.n > 0) begin
               checks++;
               if (cur_efirst != x.acc + 1 || cur_elast - cur_efirst + 1 != x.n) begin
                  errors++;
                  $display("FAIL e_window first=%0d last=%0d exp_first=%0d exp_len=%0d",
                           cur_efirst, cur_elast, x.acc + 1, x.n);
               end
            end
            checks++;
            if (cyc != x.acc + x.n + 1) begin
               errors++;
               $display("FAIL done_latency got=%0d exp=%0d", cyc - x.acc, x.n + 1);
            end
            checks++;
            if (shadow !== x.sh) begin
               errors++;
               $display("FAIL shadow_at_done got=%h exp=%h", shadow, x.sh);
            end
         end
      end
      if (valid && ready === 1'b1 && !rst) begin
         x.op = op;
         x.n  = op[1] ? 1 : int'(count);
         case (op)
            2'b00: exp_sh = exp_sh - W'(count);
            2'b01: exp_sh = exp_sh + W'(count);
            2'b10: exp_sh = data;
            default: exp_sh = '0;
         endcase
         x.sh  = exp_sh;
         x.acc = cyc;
         q.push_back(x);
         acc_total++;
         cur_ecnt = 0;
      end
      if (sync_set) synced = 1'b1;
   end

   task automatic wait_accept();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (ready !== 1'b1 && t < 100);
      if (ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout ready=%b exp=1", ready);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] d, input logic [C-1:0] c);
      @(posedge clk) #1;
      valid = 1'b1; op = o; data = d; count = c;
      wait_accept();
      @(posedge clk) #1;
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(q.size() == 0 && ready === 1'b1) && t < 400);
      if (q.size() != 0 || ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL idle_timeout pending=%0d ready=%b", q.size(), ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks += 7;
      if (e !== 1'b0)      begin errors++; $display("FAIL rst_e got=%b exp=0", e); end
      if (funsel !== 2'b0) begin errors++; $display("FAIL rst_funsel got=%b exp=00", funsel); end
      if (i_bus !== '0)    begin errors++; $display("FAIL rst_i got=%h exp=0", i_bus); end
      if (shadow !== '0)   begin errors++; $display("FAIL rst_shadow got=%h exp=0", shadow); end
      if (done !== 1'b0)   begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
      if (ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got=%b exp=1", ready); end
      if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
   endtask

   task automatic test_load();
      issue(2'b10, 16'h1234, 8'd0);
      wait_idle();
      checks++;
      if (shadow !== 16'h1234) begin errors++; $display("FAIL load_shadow got=%h exp=1234", shadow); end
   endtask

   task automatic test_step_down();
      issue(2'b10, 16'h0003, 8'd0);
      wait_idle();
      issue(2'b00, 16'h0000, 8'd5);
      wait_idle();
      checks++;
      if (shadow !== 16'hFFFE) begin errors++; $display("FAIL down_wrap got=%h exp=fffe", shadow); end
   endtask

   task automatic test_step_up_clear();
      issue(2'b10, 16'hFFFF, 8'd0);
      wait_idle();
      issue(2'b01, 16'h0000, 8'd2);
      wait_idle();
      checks++;
      if (shadow !== 16'h0001) begin errors++; $display("FAIL up_wrap got=%h exp=0001", shadow); end
      issue(2'b11, 16'hBEEF, 8'd7);
      wait_idle();
      checks++;
      if (shadow !== 16'h0000) begin errors++; $display("FAIL clear got=%h exp=0000", shadow); end
   endtask

   task automatic test_zero_count();
      issue(2'b10, 16'h00A5, 8'd0);
      wait_idle();
      issue(2'b01, 16'h0000, 8'd0);
      wait_idle();
      checks++;
      if (shadow !== 16'h00A5) begin errors++; $display("FAIL zero_count got=%h exp=00a5", shadow); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops [6] = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
      logic [C-1:0] cnts [6] = '{8'd3, 8'd2, 8'd0, 8'd1, 8'd0, 8'd4};
      int start;
      start = acc_total;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk) #1;
         valid = 1'b1; op = ops[k]; data = 16'h55AA + W'(k); count = cnts[k];
         wait_accept();
      end
      @(posedge clk) #1;
      op = 2'b01; count = 8'd9;
      #1 valid = 1'b0;
      wait_idle();
      checks++;
      if (acc_total - start != 6) begin
         errors++;
         $display("FAIL b2b_accepts got=%0d exp=6", acc_total - start);
      end
      checks++;
      if (shadow !== 16'hFFFC) begin errors++; $display("FAIL b2b_shadow got=%h exp=fffc", shadow); end
   endtask

   task automatic test_reset_mid();
      int seen = 0, t = 0;
      @(posedge clk) #1;
      valid = 1'b1; op = 2'b01; data = '0; count = 8'd10;
      wait_accept();
      @(posedge clk) #1;
      valid = 1'b0;
      while (seen < 3 && t < 50) begin
         if (e === 1'b1) seen++;
         if (seen < 3) begin @(negedge clk); t++; end
      end
      if (seen < 3) begin checks++; errors++; $display("FAIL mid_e_timeout seen=%0d exp=3", seen); end
      #1 rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      @(negedge clk);
      checks += 4;
      if (e !== 1'b0)      begin errors++; $display("FAIL mid_rst_e got=%b exp=0", e); end
      if (shadow !== '0)   begin errors++; $display("FAIL mid_rst_shadow got=%h exp=0", shadow); end
      if (ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", ready); end
      if (done !== 1'b0)   begin errors++; $display("FAIL mid_rst_done got=%b exp=0", done); end
      repeat (12) @(negedge clk);
      issue(2'b11, 16'h0000, 8'd0);
      wait_idle();
      issue(2'b10, 16'h0BAD, 8'd0);
      wait_idle();
      checks++;
      if (shadow !== 16'h0BAD) begin errors++; $display("FAIL post_rst_load got=%h exp=0bad", shadow); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_step_down();
      test_step_up_clear();
      test_zero_count();
      test_back_to_back();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
